// File: rtl/audio_meter_pkg.sv
// Shared types and helpers for the audio level meter: FSM states, the
// encoder offset and the saturating sample magnitude.
package audio_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAP    = 2'd1,
        UPDATE = 2'd2
    } state_e;

    // Peak bits at or below this position are too quiet to light any LED.
    function automatic int calc_offset(input int sample_w, input int led_n);
        return sample_w - 1 - led_n;
    endfunction

    // |s| clamped to the largest positive value of a w-bit two's complement
    // word, so the most-negative sample reads as full scale.
    function automatic logic [31:0] sat_mag(input logic signed [31:0] s, input int w);
        logic [31:0] lim;
        logic [31:0] a;
        lim = (32'd1 << (w - 1)) - 32'd1;
        a   = s[31] ? 32'(-s) : 32'(s);
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/audio_level_meter_level_encoder.sv
// Combinational log-scale mapping from a peak magnitude to a bar level:
// the position of the highest set bit, shifted down by the offset.
module level_encoder
    import audio_meter_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int LED_N    = 8,
    localparam int LW      = $clog2(LED_N + 1)
) (
    input  logic [SAMPLE_W-2:0] peak_i,
    output logic [LW-1:0]       level_o
);

    localparam int OFFSET = calc_offset(SAMPLE_W, LED_N);

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        int msb_p1;
        msb_p1 = 0;
        for (int i = 0; i < SAMPLE_W - 1; i++) begin
            if (peak_i[i]) msb_p1 = i + 1;
        end
        level_o = '0;
        if (msb_p1 > OFFSET) level_o = LW'(msb_p1 - OFFSET);
    end

endmodule

// File: rtl/audio_level_meter.sv
// Windowed peak meter: tracks the peak magnitude of each sample window and
// drives a log-scaled LED bar with peak-hold and one-step-per-window decay.
module audio_level_meter
    import audio_meter_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int WINDOW_LOG2  = 11,
    parameter int LED_N        = 8,
    parameter int HOLD_WINDOWS = 4,
    localparam int LW          = $clog2(LED_N + 1)
) (
    input  logic                CLK50MHZ,
    input  logic                reset,
    input  logic                interrupt,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [LED_N-1:0]    led_bar,
    output logic [LW-1:0]       level,
    output logic [SAMPLE_W-2:0] peak_out,
    output logic                window_done
);

    localparam int MW = SAMPLE_W - 1;
    localparam int HW = $clog2(HOLD_WINDOWS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_WINDOWS);

    logic                   interrupt_q;
    logic [MW-1:0]          running_peak_q;
    logic [MW-1:0]          latched_peak_q;
    logic [WINDOW_LOG2-1:0] sample_cnt_q;
    logic                   pending_q, pending_d;
    state_e                 state_q, state_d;
    logic [LW-1:0]          new_level_q, new_level_d;
    logic [LW-1:0]          level_q, level_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [MW-1:0]          peak_out_q, peak_out_d;
    logic [LED_N-1:0]       led_bar_q, led_bar_d;

    logic          accept;
    logic          win_end;
    logic [MW-1:0] mag;
    logic [MW-1:0] peak_max;
    logic [LW-1:0] enc_level;
    logic [LW-1:0] dec_level;

    // One acceptance per strobe, however long interrupt stays high.
    assign accept   = interrupt && !interrupt_q;
    assign mag      = MW'(sat_mag(32'(signed'(sample_in)), SAMPLE_W));
    assign peak_max = (mag > running_peak_q) ? mag : running_peak_q;
    assign win_end  = accept && (sample_cnt_q == '1);

    level_encoder #(
        .SAMPLE_W (SAMPLE_W),
        .LED_N    (LED_N)
    ) u_level_encoder (
        .peak_i  (latched_peak_q),
        .level_o (enc_level)
    );

    // NOTE: registers update with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK50MHZ) begin
        if (reset) begin
            interrupt_q    <= 1'b0;
            running_peak_q <= '0;
            latched_peak_q <= '0;
            sample_cnt_q   <= '0;
        end else begin
            interrupt_q <= interrupt;
            if (accept) begin
                if (win_end) begin
                    latched_peak_q <= peak_max;
                    running_peak_q <= '0;
                    sample_cnt_q   <= '0;
                end else begin
                    running_peak_q <= peak_max;
                    sample_cnt_q   <= sample_cnt_q + 1'b1;
                end
            end
        end
    end

    assign dec_level = level_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        new_level_d = new_level_q;
        level_d     = level_q;
        hold_cnt_d  = hold_cnt_q;
        peak_out_d  = peak_out_q;
        window_done = 1'b0;

        // A window end seen while busy is remembered and serviced from IDLE.
        if (state_q == IDLE) begin
            pending_d = 1'b0;
        end else if (win_end) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (win_end || pending_q) state_d = MAP;
            end
            MAP: begin
                new_level_d = enc_level;
                state_d     = UPDATE;
            end
            UPDATE: begin
                window_done = 1'b1;
                peak_out_d  = latched_peak_q;
                if (new_level_q >= level_q) begin
                    level_d    = new_level_q;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q < HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else begin
                    level_d = (dec_level > new_level_q) ? dec_level : new_level_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < LED_N; i++) begin
            led_bar_d[i] = (int'(level_d) > i);
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            new_level_q <= '0;
            level_q     <= '0;
            hold_cnt_q  <= '0;
            peak_out_q  <= '0;
            led_bar_q   <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            new_level_q <= new_level_d;
            level_q     <= level_d;
            hold_cnt_q  <= hold_cnt_d;
            peak_out_q  <= peak_out_d;
            led_bar_q   <= led_bar_d;
        end
    end

    assign level    = level_q;
    assign led_bar  = led_bar_q;
    assign peak_out = peak_out_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with 4-sample windows and a 2-window
// hold; expected levels are hand-derived from the log-scale mapping.
module tb_audio_level_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic [15:0] sample_in;
    logic [7:0]  led_bar;
    logic [3:0]  level;
    logic [14:0] peak_out;
    logic        window_done;

    int total     = 0;
    int passed    = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int raise_cyc = 0;

    always #5 clk = ~clk;

    audio_level_meter #(
        .SAMPLE_W     (16),
        .WINDOW_LOG2  (2),
        .LED_N        (8),
        .HOLD_WINDOWS (2)
    ) dut (
        .CLK50MHZ    (clk),
        .reset       (reset),
        .interrupt   (interrupt),
        .sample_in   (sample_in),
        .led_bar     (led_bar),
        .level       (level),
        .peak_out    (peak_out),
        .window_done (window_done)
    );

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (window_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        interrupt = 1'b0;
        sample_in = 16'h0000;
        tick();
        tick();
        reset    = 1'b0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    // Data is only valid while interrupt is high; afterwards drive junk.
    task automatic strobe(input logic [15:0] s, input int hi_len);
        sample_in = s;
        interrupt = 1'b1;
        raise_cyc = cyc;
        repeat (hi_len) tick();
        interrupt = 1'b0;
        sample_in = 16'h7FFF;
        repeat (4) tick();
    endtask

    task automatic window(input logic [15:0] a, b, c, d);
        strobe(a, 2);
        strobe(b, 2);
        strobe(c, 2);
        strobe(d, 2);
    endtask

    task automatic check_out(input string tag, input int lvl, input logic [14:0] pk);
        logic [7:0] therm;
        therm = 8'((16'd1 << lvl) - 16'd1);
        check({tag, ".level"}, 32'(level), 32'(lvl));
        check({tag, ".led_bar"}, 32'(led_bar), 32'(therm));
        check({tag, ".peak_out"}, 32'(peak_out), 32'(pk));
    endtask

    initial begin
        int exp_lvl;

        do_reset();
        check("rst.level", 32'(level), 0);
        check("rst.led_bar", 32'(led_bar), 0);
        check("rst.peak_out", 32'(peak_out), 0);
        check("rst.window_done", 32'(window_done), 0);

        // 1: four 2-cycle strobes of 0x4000 complete one window
        strobe(16'h4000, 2);
        strobe(16'h4000, 2);
        strobe(16'h4000, 2);
        check("t1.no_done_early", 32'(done_cnt), 0);
        strobe(16'h4000, 2);
        check("t1.done_cnt", 32'(done_cnt), 1);
        check("t1.done_latency", 32'(done_cyc), 32'(raise_cyc + 2));
        check_out("t1", 8, 15'h4000);

        // 2: most-negative saturates; -200 gives level 1
        window(16'h0000, 16'h0000, 16'h8000, 16'h0000);
        check_out("t2.sat", 8, 15'h7FFF);
        do_reset();
        window(16'hFF38, 16'hFF38, 16'hFF38, 16'hFF38);
        check_out("t2.neg", 1, 15'd200);

        // 3: hold for two windows, then one step of decay per window
        do_reset();
        window(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        check_out("t3.start", 8, 15'h4000);
        for (int w = 1; w <= 10; w++) begin
            window(16'h0000, 16'h0000, 16'h0000, 16'h0000);
            exp_lvl = (w <= 2) ? 8 : ((8 - (w - 2)) > 0 ? 8 - (w - 2) : 0);
            check($sformatf("t3.decay%0d", w), 32'(level), 32'(exp_lvl));
        end
        check("t3.peak_zero", 32'(peak_out), 0);
        check("t3.done_cnt", 32'(done_cnt), 11);

        // 4: decay floor follows new_level; a rise restarts hold
        do_reset();
        window(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        window(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        window(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("t4.held", 32'(level), 8);
        window(16'h0100, 16'h0000, 16'h0000, 16'h0000);
        check_out("t4.floor", 7, 15'h0100);
        for (int w = 0; w < 4; w++) begin
            window(16'h0100, 16'h0100, 16'h0100, 16'h0100);
            check($sformatf("t4.down%0d", w), 32'(level), 32'(6 - w));
        end
        window(16'h0000, 16'h0800, 16'h0000, 16'h0000);
        check_out("t4.rise", 5, 15'h0800);
        window(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("t4.rehold1", 32'(level), 5);
        window(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("t4.rehold2", 32'(level), 5);
        window(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("t4.redecay", 32'(level), 4);

        // 5: reset mid-window discards the partial window
        do_reset();
        strobe(16'h7FFF, 2);
        strobe(16'h7FFF, 2);
        do_reset();
        strobe(16'h0100, 2);
        strobe(16'h0100, 2);
        strobe(16'h0100, 2);
        check("t5.no_done_early", 32'(done_cnt), 0);
        strobe(16'h0100, 2);
        check("t5.done_cnt", 32'(done_cnt), 1);
        check_out("t5", 2, 15'h0100);

        // 6: 10-cycle strobes still count once each
        do_reset();
        strobe(16'h0100, 10);
        strobe(16'h0200, 10);
        strobe(16'h0400, 10);
        check("t6.no_done_early", 32'(done_cnt), 0);
        strobe(16'h0800, 10);
        check("t6.done_cnt", 32'(done_cnt), 1);
        check("t6.done_latency", 32'(done_cyc), 32'(raise_cyc + 2));
        check_out("t6", 5, 15'h0800);
        strobe(16'h0010, 10);
        check("t6.no_extra_done", 32'(done_cnt), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
